// File: rtl/pattern_scan_ctrl.sv
// Pattern scan controller: sequences a programmable serial pattern search over
// a qualified bit stream, counts matches and stops on limit, window or abort.
//
// Optional feature macro: PATTERN_MASK_EN (adds cfg_mask_i, 0 = don't-care bit).
//
// Ports:
//   clk_i, reset_i          clock (rising edge), async active-high reset
//   cfg_pattern_i/len_i     pattern (bit 0 = most recent bit) and its length
//   cfg_overlap_i           allow overlapping matches
//   cfg_limit_i/window_i    match limit / valid-bit window, 0 = unlimited
//   start_i, abort_i        arm request (IDLE only) / terminate active scan
//   data_i, data_valid_i    serial stream and qualifier
//   busy_o, match_o, done_o scan active, match pulse, termination pulse
//   match_count_o           matches in current/last scan
//   bit_count_o             valid bits consumed in current/last scan
//   status_o                00 none, 01 limit, 10 window, 11 aborted
module pattern_scan_ctrl #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned WIN_W   = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
`ifdef PATTERN_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask_i,
`endif
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic [CNT_W-1:0]   cfg_limit_i,
    input  logic [WIN_W-1:0]   cfg_window_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               data_i,
    input  logic               data_valid_i,
    output logic               busy_o,
    output logic               match_o,
    output logic [CNT_W-1:0]   match_count_o,
    output logic [WIN_W-1:0]   bit_count_o,
    output logic               done_o,
    output logic [1:0]         status_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_LIMIT  = 2'b01;
    localparam logic [1:0] ST_WINDOW = 2'b10;
    localparam logic [1:0] ST_ABORT  = 2'b11;

    state_t             state_q, state_n;
    logic [MAX_LEN-1:0] shift_q, shift_n, pat_q, pat_n;
    logic [LEN_W-1:0]   fill_q, fill_n, len_q, len_n;
    logic               ovl_q, ovl_n;
    logic [CNT_W-1:0]   lim_q, lim_n, count_n;
    logic [WIN_W-1:0]   win_q, win_n, bits_n;
    logic [1:0]         status_n;
    logic               match_n, busy_n, done_n;
`ifdef PATTERN_MASK_EN
    logic [MAX_LEN-1:0] mask_q, mask_n;
`endif

    logic [MAX_LEN-1:0] shift_nx, len_mask, mask_eff;
    logic [LEN_W-1:0]   fill_nx, len_clamped;
    logic [CNT_W-1:0]   count_inc;
    logic [WIN_W-1:0]   bits_inc;
    logic               hit, lim_ev, win_ev;

    // Next-state, datapath and output decode
    always_comb begin
        state_n  = state_q;
        shift_n  = shift_q;
        fill_n   = fill_q;
        pat_n    = pat_q;
        len_n    = len_q;
        ovl_n    = ovl_q;
        lim_n    = lim_q;
        win_n    = win_q;
        count_n  = match_count_o;
        bits_n   = bit_count_o;
        status_n = status_o;
        match_n  = 1'b0;
`ifdef PATTERN_MASK_EN
        mask_n   = mask_q;
        mask_eff = mask_q;
`else
        mask_eff = '1;
`endif

        // Length 0 behaves as 1; oversize lengths clamp to the register width
        if (cfg_len_i == '0)
            len_clamped = LEN_W'(1);
        else if (cfg_len_i > LEN_W'(MAX_LEN))
            len_clamped = LEN_W'(MAX_LEN);
        else
            len_clamped = cfg_len_i;

        for (int i = 0; i < int'(MAX_LEN); i++)
            len_mask[i] = (LEN_W'(i) < len_q);

        shift_nx  = {shift_q[MAX_LEN-2:0], data_i};
        fill_nx   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        hit       = (fill_nx == len_q) &&
                    (((shift_nx ^ pat_q) & len_mask & mask_eff) == '0);
        count_inc = (&match_count_o) ? match_count_o : match_count_o + CNT_W'(1);
        bits_inc  = (&bit_count_o) ? bit_count_o : bit_count_o + WIN_W'(1);
        lim_ev    = hit && (lim_q != '0) && (count_inc == lim_q);
        win_ev    = (win_q != '0) && (bits_inc == win_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_n  = SCAN;
                    pat_n    = cfg_pattern_i;
                    len_n    = len_clamped;
                    ovl_n    = cfg_overlap_i;
                    lim_n    = cfg_limit_i;
                    win_n    = cfg_window_i;
`ifdef PATTERN_MASK_EN
                    mask_n   = cfg_mask_i;
`endif
                    shift_n  = '0;
                    fill_n   = '0;
                    count_n  = '0;
                    bits_n   = '0;
                    status_n = ST_NONE;
                end
            end
            SCAN: begin
                // Abort suppresses any bit presented in the same cycle
                if (abort_i) begin
                    state_n  = DONE;
                    status_n = ST_ABORT;
                end else if (data_valid_i) begin
                    shift_n = shift_nx;
                    bits_n  = bits_inc;
                    fill_n  = (hit && !ovl_q) ? '0 : fill_nx;
                    if (hit) begin
                        match_n = 1'b1;
                        count_n = count_inc;
                    end
                    if (lim_ev) begin
                        state_n  = DONE;
                        status_n = ST_LIMIT;
                    end else if (win_ev) begin
                        state_n  = DONE;
                        status_n = ST_WINDOW;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == SCAN);
        done_n = (state_n == DONE);
    end

    // State, shadow config and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            fill_q        <= '0;
            pat_q         <= '0;
            len_q         <= '0;
            ovl_q         <= 1'b0;
            lim_q         <= '0;
            win_q         <= '0;
`ifdef PATTERN_MASK_EN
            mask_q        <= '0;
`endif
            busy_o        <= 1'b0;
            match_o       <= 1'b0;
            match_count_o <= '0;
            bit_count_o   <= '0;
            done_o        <= 1'b0;
            status_o      <= ST_NONE;
        end else begin
            state_q       <= state_n;
            shift_q       <= shift_n;
            fill_q        <= fill_n;
            pat_q         <= pat_n;
            len_q         <= len_n;
            ovl_q         <= ovl_n;
            lim_q         <= lim_n;
            win_q         <= win_n;
`ifdef PATTERN_MASK_EN
            mask_q        <= mask_n;
`endif
            busy_o        <= busy_n;
            match_o       <= match_n;
            match_count_o <= count_n;
            bit_count_o   <= bits_n;
            done_o        <= done_n;
            status_o      <= status_n;
        end
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Controller that sequences a programmable serial pattern search over a gated bit stream.
- Latches a search configuration on start and shifts qualified input bits.
- Counts pattern matches and terminates on match limit, observation window expiry or abort.
- Reports a status code to the host.
- Sits between the control/register logic and the serial data_i stream.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of cfg_len_i; must hold MAX_LEN
CNT_W, 8, width of match counter and match limit
WIN_W, 16, width of window length and bit counter

Ports:
clk_i  input  1  clock, all flops rising edge
reset_i  input  1  asynchronous, active-high reset
cfg_pattern_i  input  MAX_LEN  pattern; bit 0 = most recent bit
cfg_len_i  input  LEN_W  pattern length; 0 treated as 1, >MAX_LEN clamped to MAX_LEN
cfg_overlap_i  input  1  1 = overlapping matches allowed
cfg_limit_i  input  CNT_W  stop after this many matches; 0 = unlimited
cfg_window_i  input  WIN_W  stop after this many valid bits; 0 = unlimited
start_i  input  1  arm request, sampled in IDLE only
abort_i  input  1  terminate an active scan
data_i  input  1  serial data bit
data_valid_i  input  1  data_i qualifier
busy_o  output  1  high while in SCAN
match_o  output  1  one-cycle match pulse
match_count_o  output  CNT_W  matches in current/last scan
bit_count_o  output  WIN_W  valid bits consumed in current/last scan
done_o  output  1  one-cycle termination pulse
status_o  output  2  00 none, 01 limit, 10 window, 11 aborted

Behaviour:
- Reset: state IDLE. All outputs 0. Shift register, fill counter and shadow config are 0.
- States:
  - IDLE -> SCAN on start_i. start_i also latches all cfg_* into shadow registers and clears shift register, fill, match_count_o, bit_count_o and status_o.
  - SCAN -> DONE on abort, limit or window event.
  - DONE -> IDLE unconditionally after one cycle.
- cfg_* changes after start have no effect until the next start.
- start_i in SCAN or DONE is ignored. data_valid_i outside SCAN is ignored.
- SCAN, per data_valid_i bit:
  - shift <= {shift[MAX_LEN-2:0], data_i}
  - bit_count_o increments, saturating at all-ones
  - fill_next = min(fill+1, len)
- Match condition: fill_next == len and shift_next[len-1:0] == pattern[len-1:0].
- On match:
  - match_o is high for the cycle after the sampling edge (registered, 1-cycle latency).
  - match_count_o increments on the same edge, saturating.
  - If overlap = 0, fill is reset to 0; otherwise fill stays at len.
- Termination, evaluated on the same edge as the bit:
  - Limit: limit != 0 and new count == limit -> DONE, status 01.
  - Window: window != 0 and new bit_count == window -> DONE, status 10.
  - Limit and window on the same bit -> status 01.
- Abort:
  - abort_i in SCAN -> DONE, status 11. Abort wins over a simultaneous bit: the bit is not shifted or counted, and match_o stays 0.
  - abort_i in IDLE/DONE is ignored.
- DONE: done_o = 1 and busy_o = 0 for exactly one cycle. match_o may be high in the same cycle if the terminating bit matched.
- status_o, match_count_o and bit_count_o hold until the next accepted start.
- Reset mid-scan returns to IDLE with all outputs 0 asynchronously.

Optional Feature:
PATTERN_MASK_EN
- Defined: adds input cfg_mask_i [MAX_LEN-1:0], latched on start like the other cfg_* inputs. The compare becomes ((shift_next ^ pattern) & mask)[len-1:0] == 0, so mask bit 0 means don't-care.
- Undefined: port absent; exact compare over len bits.

Test Plan:
- Overlap hits: pattern 3'b101, len 3, overlap 1, limit 0, window 0; stream 1,0,1,0,1.
  - match_o pulses after bits 3 and 5; match_count_o = 2; busy_o stays 1.
- Non-overlap: same setup with overlap 0; stream 1,0,1,0,1 -> single match after bit 3; match_count_o = 1.
- Limit: pattern 2'b11, len 2, overlap 1, limit 2; stream 1,1,1,1.
  - Second match on bit 3: done_o = 1, status_o = 01, match_count_o = 2.
  - Bit 4 ignored; bit_count_o = 3.
- Window: pattern 3'b111, window 4; stream 0,0,0,0 -> done_o after bit 4, status_o = 10, match_count_o = 0, bit_count_o = 4.
- Abort priority: in SCAN, abort_i together with a bit completing a match.
  - Next cycle: done_o = 1, status_o = 11, match_o = 0, counts unchanged.
  - start_i asserted during SCAN earlier in the same test has no effect.
- Reset mid-scan: assert reset_i after 5 bits -> busy_o, match_count_o, bit_count_o and status_o are 0 immediately; a new start re-arms cleanly.
